controle_somador: RTL and testbench

Sequencing controller for the 4-bit adder/subtractor datapath on the board. It captures operand A, operand B and the operation from switches on successive debounced ENTER key presses, and drives the adder's A, B and SINAL inputs. It registers the adder's 6-bit two's-complement result as sign plus magnitude for the BCD display blocks, and counts completed operations. It sits between the board switches/keys and the combinational adder; the display decoders consume its registered outputs.

---
 rtl/controle_somador.sv | 121 ++++++++++++
 tb/tb_controle_somador.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/controle_somador.sv
// Operand/operation sequencer for the 4-bit adder board: ENTER key path, capture FSM, sign/magnitude result.
// Optional DEBOUNCE_EN macro inserts a DEBOUNCE_CYCLES-long stability filter on the synchronized key.
`timescale 1ns/1ps
module controle_somador #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] SW_DADO,
    input  logic       SW_OP,
    input  logic       KEY_ENTRA,
    input  logic [5:0] SOMA,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       SINAL,
    output logic [4:0] RES_MAG,
    output logic       RES_NEG,
    output logic [1:0] ESTADO,
    output logic       VALIDO,
    output logic [7:0] CONT_OPS
);

    typedef enum logic [1:0] {
        ESPERA_A = 2'b00,
        ESPERA_B = 2'b01,
        CALCULA  = 2'b10,
        MOSTRA   = 2'b11
    } estado_t;

    estado_t    estado;
    logic [1:0] sync;
    logic       sync_ok;
    logic       armado;
    logic       filt;
    logic       filt_d;
    logic       enter;

    // A key held through reset must be seen released before it can fire, so the
    // edge detector stays disarmed until a real high level reaches the synchronizer.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync    <= 2'b11;
            sync_ok <= 1'b0;
            armado  <= 1'b0;
            filt_d  <= 1'b1;
        end else begin
            sync    <= {sync[0], KEY_ENTRA};
            sync_ok <= 1'b1;
            if (sync_ok && sync[0])
                armado <= 1'b1;
            filt_d  <= filt;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            filt <= 1'b1;
            cnt  <= '0;
        end else if (sync[1] == filt) begin
            cnt  <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
            filt <= sync[1];
            cnt  <= '0;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end
`else
    localparam int unused_debounce = DEBOUNCE_CYCLES;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) filt <= 1'b1;
        else       filt <= sync[1];
    end
`endif

    assign enter  = armado & filt_d & ~filt;
    assign ESTADO = estado;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            estado   <= ESPERA_A;
            A        <= 4'd0;
            B        <= 4'd0;
            SINAL    <= 1'b0;
            RES_MAG  <= 5'd0;
            RES_NEG  <= 1'b0;
            VALIDO   <= 1'b0;
            CONT_OPS <= 8'd0;
        end else begin
            case (estado)
                ESPERA_A: if (enter) begin
                    A      <= SW_DADO;
                    VALIDO <= 1'b0;
                    estado <= ESPERA_B;
                end
                ESPERA_B: if (enter) begin
                    B      <= SW_DADO;
                    SINAL  <= SW_OP;
                    estado <= CALCULA;
                end
                CALCULA: begin
                    // Range is -15..+30, so the low five bits always hold the magnitude.
                    RES_NEG  <= SOMA[5];
                    RES_MAG  <= SOMA[5] ? (~SOMA[4:0] + 5'd1) : SOMA[4:0];
                    VALIDO   <= 1'b1;
                    CONT_OPS <= CONT_OPS + 8'd1;
                    estado   <= MOSTRA;
                end
                MOSTRA: if (enter)
                    estado <= ESPERA_A;
                default: estado <= ESPERA_A;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_somador.sv
// Bench for controle_somador: vector table, directed key/reset sequences, random ops vs arithmetic model.
`timescale 1ns/1ps
module tb_controle_somador;
    localparam int DEB = 4;
`ifdef DEBOUNCE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_dado = 4'd0;
    logic       sw_op = 1'b0;
    logic       key = 1'b1;
    logic [5:0] soma;
    logic [3:0] a, b;
    logic       sinal, res_neg, valido;
    logic [4:0] res_mag;
    logic [1:0] estado;
    logic [7:0] cont_ops;

    controle_somador #(.DEBOUNCE_CYCLES(DEB)) dut (
        .CLOCK_50(clk), .RESET(rst), .SW_DADO(sw_dado), .SW_OP(sw_op),
        .KEY_ENTRA(key), .SOMA(soma), .A(a), .B(b), .SINAL(sinal),
        .RES_MAG(res_mag), .RES_NEG(res_neg), .ESTADO(estado),
        .VALIDO(valido), .CONT_OPS(cont_ops)
    );

    always #5 clk = ~clk;

    // Combinational adder/subtractor of the board
    assign soma = sinal ? 6'({2'b00, a} - {2'b00, b}) : 6'({2'b00, a} + {2'b00, b});

    int vectors = 0, miscompares = 0;
    int m_a = 0, m_b = 0, m_op = 0, m_neg = 0, m_mag = 0, m_cnt = 0, m_valid = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       op;
        logic       neg;
        logic [4:0] mag;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d, input logic op);
        sw_dado = d;
        sw_op   = op;
        key     = 1'b0;
        cyc(LAT + 3);
        key     = 1'b1;
        cyc(LAT + 3);
    endtask

    task automatic ref_calc(input int x, input int y, input int op, output int neg, output int mag);
        int r;
        r   = op ? x - y : x + y;
        neg = (r < 0) ? 1 : 0;
        mag = (r < 0) ? -r : r;
    endtask

    task automatic check_all(input string tag, input int st);
        chk($sformatf("%s ESTADO", tag), estado, st);
        chk($sformatf("%s A", tag), a, m_a);
        chk($sformatf("%s B", tag), b, m_b);
        chk($sformatf("%s SINAL", tag), sinal, m_op);
        chk($sformatf("%s RES_NEG", tag), res_neg, m_neg);
        chk($sformatf("%s RES_MAG", tag), res_mag, m_mag);
        chk($sformatf("%s VALIDO", tag), valido, m_valid);
        chk($sformatf("%s CONT_OPS", tag), cont_ops, m_cnt);
    endtask

    // Second half of an operation: B press from ESPERA_B, model updated afterwards.
    task automatic finish_op(input int y, input int op);
        press(4'(y), 1'(op));
        m_b = y; m_op = op;
        ref_calc(m_a, m_b, m_op, m_neg, m_mag);
        m_cnt   = (m_cnt + 1) % 256;
        m_valid = 1;
    endtask

    // Full operation starting from ESPERA_A; SW_OP is deliberately wrong during the A press.
    task automatic run_op(input int x, input int y, input int op);
        press(4'(x), 1'(~op));
        m_a = x; m_valid = 0;
        finish_op(y, op);
    endtask

    int n, neg_t, mag_t;

    initial begin
        tbl[0] = '{4'd5,  4'd9,  1'b1, 1'b1, 5'd4};
        tbl[1] = '{4'd15, 4'd15, 1'b0, 1'b0, 5'd30};
        tbl[2] = '{4'd7,  4'd7,  1'b1, 1'b0, 5'd0};
        tbl[3] = '{4'd0,  4'd15, 1'b1, 1'b1, 5'd15};
        tbl[4] = '{4'd0,  4'd0,  1'b0, 1'b0, 5'd0};
        tbl[5] = '{4'd8,  4'd3,  1'b1, 1'b0, 5'd5};
        tbl[6] = '{4'd9,  4'd6,  1'b0, 1'b0, 5'd15};

        cyc(3);
        rst = 1'b0;
        cyc(2);
        check_all("reset", 0);

        // Table vectors; expected sign/magnitude come from the table itself
        for (int i = 0; i < 7; i++) begin
            if (i != 0) press(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            run_op(tbl[i].a, tbl[i].b, tbl[i].op);
            chk($sformatf("tbl%0d RES_NEG", i), res_neg, tbl[i].neg);
            chk($sformatf("tbl%0d RES_MAG", i), res_mag, tbl[i].mag);
            check_all($sformatf("tbl%0d", i), 3);
        end

        // Switch activity in MOSTRA without a press changes nothing
        for (int i = 0; i < 10; i++) begin
            sw_dado = 4'($urandom_range(0, 15));
            sw_op   = 1'($urandom_range(0, 1));
            cyc(3);
        end
        check_all("mostra hold", 3);

        // Press latency and single transition while held
        key = 1'b0;
        n = 0;
        while (estado == 2'd3 && n < 60) begin
            cyc(1);
            n++;
        end
        chk("enter latency", n - 1, LAT);
        cyc(100);
        chk("held 100 ESTADO", estado, 0);
        chk("held 100 VALIDO", valido, 1);
        key = 1'b1;
        cyc(LAT + 3);

`ifdef DEBOUNCE_EN
        key = 1'b0;
        cyc(DEB - 1);
        key = 1'b1;
        cyc(20);
        chk("glitch ESTADO", estado, 0);
`endif

        // Reset in ESPERA_B after A=12
        press(4'd12, 1'b0);
        chk("pre-reset ESTADO", estado, 1);
        chk("pre-reset A", a, 12);
        chk("pre-reset VALIDO", valido, 0);
        rst = 1'b1;
        #1;
        m_a = 0; m_b = 0; m_op = 0; m_neg = 0; m_mag = 0; m_cnt = 0; m_valid = 0;
        check_all("async reset", 0);
        key = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(3 * (LAT + 3));
        chk("held thru reset ESTADO", estado, 0);
        key = 1'b1;
        cyc(LAT + 3);
        press(4'd7, 1'b1);
        m_a = 7;
        chk("repress ESTADO", estado, 1);
        chk("repress A", a, 7);
        finish_op(3, 0);
        check_all("post-reset op", 3);

        // Random operations until the counter wraps
        while (m_cnt != 0) begin
            press(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
            ref_calc(m_a, m_b, m_op, neg_t, mag_t);
            chk("rand RES_NEG", res_neg, neg_t);
            chk("rand RES_MAG", res_mag, mag_t);
            chk("rand CONT_OPS", cont_ops, m_cnt);
            if (m_cnt == 255) check_all("count 255", 3);
        end
        check_all("wrap", 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
